// File: rtl/mul_seq_ctrl_if.sv
// Request/response handshake and multiplier-cell bus for the multiply sequencer.
// The slave modport is the controller; the master modport is whoever drives it.
interface mul_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        mul_en;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, mul_p, resp_ready,
    output req_ready, mul_en, mul_a, mul_b, resp_valid, resp_result, busy
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, mul_p, resp_ready,
    input  req_ready, mul_en, mul_a, mul_b, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// 32x32 multiply sequencer: four 16x16 unsigned partial products through an external
// pipelined multiplier, 64-bit accumulate, sign fix-up, then the selected 32-bit half.
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  mul_seq_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIXUP, RESP} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [1:0]  r_op;
  logic        r_neg;
  logic [31:0] r_magA;
  logic [31:0] r_magB;
  logic [63:0] r_acc;
  logic [1:0]  r_pass;
  logic [15:0] r_mulA;
  logic [15:0] r_mulB;
  logic [31:0] r_result;
  logic [MUL_LATENCY-1:0] r_pipeValid;
  logic [1:0]  r_pipeIdx [MUL_LATENCY];

  logic        w_accept;
  logic        w_srcNegA;
  logic        w_srcNegB;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic        w_pipeOutValid;
  logic [1:0]  w_pipeOutIdx;
  logic [63:0] w_addend;
  logic [63:0] w_accFixed;

  assign w_accept  = bus.req_valid && (r_state == IDLE);
  assign w_srcNegA = bus.req_op[1] && bus.req_src1[31];
  assign w_srcNegB = (bus.req_op == 2'b10) && bus.req_src2[31];
  // Two's-complement negate leaves 0x80000000 as itself, which is its unsigned magnitude.
  assign w_magA    = w_srcNegA ? (~bus.req_src1 + 32'd1) : bus.req_src1;
  assign w_magB    = w_srcNegB ? (~bus.req_src2 + 32'd1) : bus.req_src2;

  assign w_pipeOutValid = r_pipeValid[MUL_LATENCY-1];
  assign w_pipeOutIdx   = r_pipeIdx[MUL_LATENCY-1];
  assign w_accFixed     = r_neg ? (~r_acc + 64'd1) : r_acc;

  always_comb begin
    w_addend = 64'd0;
    case (w_pipeOutIdx)
      2'd0:    w_addend = {32'd0, bus.mul_p};
      2'd1,
      2'd2:    w_addend = {16'd0, bus.mul_p, 16'd0};
      default: w_addend = {bus.mul_p, 32'd0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = ISSUE;
      ISSUE:   if (r_pass == 2'd3) w_stateNext = DRAIN;
      DRAIN:   if (w_pipeOutValid && (w_pipeOutIdx == 2'd3)) w_stateNext = FIXUP;
      FIXUP:   w_stateNext = RESP;
      RESP:    if (bus.resp_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op     <= 2'd0;
      r_neg    <= 1'b0;
      r_magA   <= 32'd0;
      r_magB   <= 32'd0;
      r_acc    <= 64'd0;
      r_pass   <= 2'd0;
      r_mulA   <= 16'd0;
      r_mulB   <= 16'd0;
      r_result <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.req_op;
        r_neg  <= w_srcNegA ^ w_srcNegB;
        r_magA <= w_magA;
        r_magB <= w_magB;
        r_pass <= 2'd0;
        r_mulA <= w_magA[15:0];
        r_mulB <= w_magB[15:0];
      end else if (r_state == ISSUE) begin
        // Operands for the following pass are staged while the current one issues.
        r_pass <= r_pass + 2'd1;
        case (r_pass)
          2'd0: begin r_mulA <= r_magA[31:16]; r_mulB <= r_magB[15:0];  end
          2'd1: begin r_mulA <= r_magA[15:0];  r_mulB <= r_magB[31:16]; end
          2'd2: begin r_mulA <= r_magA[31:16]; r_mulB <= r_magB[31:16]; end
          default: ;
        endcase
      end

      if (w_accept)                r_acc <= 64'd0;
      else if (w_pipeOutValid)     r_acc <= r_acc + w_addend;
      else if (r_state == FIXUP)   r_acc <= w_accFixed;

      if (r_state == FIXUP)
        r_result <= (r_op == 2'b00) ? w_accFixed[31:0] : w_accFixed[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        r_pipeValid[i] <= 1'b0;
        r_pipeIdx[i]   <= 2'd0;
      end
    end else begin
      r_pipeValid[0] <= (r_state == ISSUE);
      r_pipeIdx[0]   <= r_pass;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeIdx[i]   <= r_pipeIdx[i-1];
      end
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.mul_en      = (r_state == ISSUE);
  assign bus.mul_a       = r_mulA;
  assign bus.mul_b       = r_mulB;
  assign bus.resp_valid  = (r_state == RESP);
  assign bus.resp_result = r_result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl at multiplier latencies 1 and 3, each DUT paired
// with a behavioural pipelined 16x16 multiplier.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        useL3;
  logic        tReqValid;
  logic [1:0]  tOp;
  logic [31:0] tA;
  logic [31:0] tB;
  logic        tRespReady;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  mul_seq_ctrl_if if1();
  mul_seq_ctrl_if if3();

  mul_seq_ctrl #(.MUL_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  mul_seq_ctrl #(.MUL_LATENCY(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));

  assign if1.req_valid  = tReqValid & ~useL3;
  assign if3.req_valid  = tReqValid & useL3;
  assign if1.req_op     = tOp;
  assign if3.req_op     = tOp;
  assign if1.req_src1   = tA;
  assign if3.req_src1   = tA;
  assign if1.req_src2   = tB;
  assign if3.req_src2   = tB;
  assign if1.resp_ready = tRespReady;
  assign if3.resp_ready = tRespReady;

  // Behavioural multiplier cells: one and three register stages.
  logic [31:0] mp1;
  logic [31:0] mp3 [3];
  always @(posedge clk) begin
    mp1    <= {16'd0, if1.mul_a} * {16'd0, if1.mul_b};
    mp3[0] <= {16'd0, if3.mul_a} * {16'd0, if3.mul_b};
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign if1.mul_p = mp1;
  assign if3.mul_p = mp3[2];

  wire        oReqReady   = useL3 ? if3.req_ready   : if1.req_ready;
  wire        oRespValid  = useL3 ? if3.resp_valid  : if1.resp_valid;
  wire [31:0] oRespResult = useL3 ? if3.resp_result : if1.resp_result;
  wire        oMulEn      = useL3 ? if3.mul_en      : if1.mul_en;
  wire [15:0] oMulA       = useL3 ? if3.mul_a       : if1.mul_a;
  wire [15:0] oMulB       = useL3 ? if3.mul_b       : if1.mul_b;
  wire        oBusy       = useL3 ? if3.busy        : if1.busy;

  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = (op[1] && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
    bx = ((op == 2'b10) && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkResetOutputs(input string name);
    logic [67:0] got;
    got = {oReqReady, oRespValid, oRespResult, oMulEn, oMulA, oMulB, oBusy};
    checks++;
    if (got !== {1'b1, 1'b0, 32'd0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL %s: outputs rdy=%b vld=%b res=%h en=%b a=%h b=%h busy=%b, required rdy=1 vld=0 res=0 en=0 a=0 b=0 busy=0",
               name, oReqReady, oRespValid, oRespResult, oMulEn, oMulA, oMulB, oBusy);
    end
  endtask

  // Entered just after a negedge; returns in cycle 1 (the negedge after the accept edge).
  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit holdValid);
    int n;
    tOp = op; tA = a; tB = b; tReqValid = 1'b1;
    n = 0;
    while (!oReqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL acceptTimeout: req_ready still %b after %0d cycles, required 1", oReqReady, n);
    end
    @(negedge clk);
    if (!holdValid) tReqValid = 1'b0;
  endtask

  task automatic waitResp(output int cyc, output int pulses);
    cyc = 1; pulses = 0;
    while (!oRespValid && cyc < 40) begin
      if (oMulEn) pulses++;
      @(negedge clk);
      cyc++;
    end
    if (!oRespValid) begin
      checks++; errors++;
      $display("[TB] FAIL respTimeout: resp_valid %b after %0d cycles, required 1", oRespValid, cyc);
    end
  endtask

  task automatic popCompare(input string name);
    logic [31:0] e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: result %h with empty scoreboard, required no response", name, oRespResult);
    end else begin
      e = expQ.pop_front();
      if (oRespResult !== e) begin
        errors++;
        $display("[TB] FAIL %s: result %h, required %h", name, oRespResult, e);
      end
    end
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int cyc, pulses;
    expQ.push_back(exp);
    startOp(op, a, b, 1'b0);
    waitResp(cyc, pulses);
    checks++;
    if (cyc !== lat) begin
      errors++;
      $display("[TB] FAIL latency: op=%0d resp_valid at cycle %0d, required %0d", op, cyc, lat);
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("[TB] FAIL mulEnPulses: op=%0d saw %0d, required 4", op, pulses);
    end
    popCompare($sformatf("result op=%0d a=%h b=%h", op, a, b));
    @(negedge clk);
    checks++;
    if (oReqReady !== 1'b1 || oRespValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idleAfterResp: req_ready=%b resp_valid=%b, required 1 0", oReqReady, oRespValid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    useL3 = 1'b0; #1;
    checkResetOutputs("resetL1");
    useL3 = 1'b1; #1;
    checkResetOutputs("resetL3");
    useL3 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_ops(input int lat);
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, lat);
    runOp(2'b00, 32'h00010001, 32'h00010001, 32'h00020001, lat);
    runOp(2'b01, 32'h00010001, 32'h00010001, 32'h00000001, lat);
    runOp(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, lat);
    runOp(2'b10, 32'h80000000, 32'h80000000, 32'h40000000, lat);
    runOp(2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, lat);
    runOp(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    runOp(2'b11, 32'h00000002, 32'h80000000, 32'h00000001, lat);
  endtask

  task automatic test_random(input int n, input int lat);
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      runOp(op, a, b, refMul(op, a, b), lat);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, pulses;
    logic [31:0] held;
    tRespReady = 1'b0;
    expQ.push_back(32'hFFFFFFFE);
    startOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    tOp = 2'b00; tA = 32'd3; tB = 32'd5;
    expQ.push_back(32'h0000000F);
    waitResp(cyc, pulses);
    popCompare("bpFirstResult");
    held = oRespResult;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (oRespResult !== held || oReqReady !== 1'b0 || oRespValid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bpHold: res=%h rdy=%b vld=%b, required res=%h rdy=0 vld=1", oRespResult, oReqReady, oRespValid, held);
      end
    end
    tRespReady = 1'b1;
    @(negedge clk);
    checks++;
    if (oReqReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bpReadyAfterHandshake: req_ready=%b, required 1", oReqReady);
    end
    @(negedge clk);
    tReqValid = 1'b0;
    checks++;
    if (oBusy !== 1'b1 || oReqReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bpSecondAccept: busy=%b req_ready=%b, required 1 0", oBusy, oReqReady);
    end
    waitResp(cyc, pulses);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("[TB] FAIL bpSecondLatency: cycle %0d, required 7", cyc);
    end
    popCompare("bpSecondResult");
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bit sawResp;
    startOp(2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (oMulEn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midopIssuing: mul_en=%b, required 1", oMulEn);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("midopReset");
    reset_n = 1'b1;
    sawResp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (oRespValid) sawResp = 1'b1;
    end
    checks++;
    if (sawResp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midopNoResp: resp_valid seen=%b, required 0", sawResp);
    end
    runOp(2'b01, 32'd3, 32'd5, 32'h00000000, 7);
    runOp(2'b00, 32'd3, 32'd5, 32'h0000000F, 7);
  endtask

  task automatic test_latency3();
    useL3 = 1'b1;
    @(negedge clk);
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9);
    runOp(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 9);
    runOp(2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 9);
    runOp(2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 9);
    test_random(4, 9);
    useL3 = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    useL3      = 1'b0;
    tReqValid  = 1'b0;
    tOp        = 2'b00;
    tA         = 32'd0;
    tB         = 32'd0;
    tRespReady = 1'b1;
    @(negedge clk);
    test_reset();
    test_plan_ops(7);
    test_random(6, 7);
    test_back_to_back();
    test_reset_midop();
    test_latency3();
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboardEmpty: %0d entries left, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer for the Nios II-style multiply unit on the DE0-Nano design.
- Accepts one 32x32 multiply request (MUL, MULXUU, MULXSS, MULXSU) through a valid/ready handshake.
- Issues four 16x16 unsigned partial products to an external pipelined dedicated-multiplier cell, accumulates them into a 64-bit product, applies the sign fix-up, and returns the selected 32-bit half.

Parameters:
- MUL_LATENCY, 1, clock cycles from mul_a/mul_b/mul_en sampled to mul_p valid; legal values 1..3.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  reset; one clock, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request (high only in IDLE)
- req_op  input  2  00 MUL (low 32), 01 MULXUU, 10 MULXSS, 11 MULXSU (high 32)
- req_src1  input  32  operand A (signed for MULXSS/MULXSU)
- req_src2  input  32  operand B (signed for MULXSS only)
- mul_en  output  1  partial-product issue strobe
- mul_a  output  16  multiplier input A, unsigned
- mul_b  output  16  multiplier input B, unsigned
- mul_p  input  32  multiplier product, valid MUL_LATENCY cycles after mul_en
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_result  output  32  selected product half
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low at a clk edge), regardless of current state:
  - state=IDLE; req_ready=1; resp_valid=0; resp_result=0; mul_en=0; mul_a=0; mul_b=0; busy=0.
  - Accumulator and latency pipe cleared; any in-flight operation is discarded with no response.
- States: IDLE -> ISSUE -> DRAIN -> FIXUP -> RESP -> IDLE.
- IDLE:
  - Accept on req_valid & req_ready (cycle 0).
  - Latch op and a sign flag: neg = (op=10 & A[31]^B[31]) | (op=11 & A[31]).
  - Latch magnitudes: |A| when op is 10 or 11; |B| when op is 10; otherwise the raw value.
  - Magnitude of 0x80000000 is 0x80000000 as an unsigned 32-bit value.
  - Clear acc[63:0]; go to ISSUE.
- ISSUE (cycles 1..4), mul_en=1, one pass per cycle:
  - Pass 0: Alo*Blo
  - Pass 1: Ahi*Blo
  - Pass 2: Alo*Bhi
  - Pass 3: Ahi*Bhi
  - After pass 3, go to DRAIN.
- Latency pipe: a MUL_LATENCY-deep shift register of {valid, pass_idx}. When it emerges valid, add to acc:
  - pass 0: mul_p
  - pass 1 and pass 2: mul_p<<16
  - pass 3: mul_p<<32
  - All additions are 64-bit, modulo 2^64.
- ISSUE and DRAIN may overlap accumulation. Exit DRAIN to FIXUP the cycle after the pass-3 product is accumulated. Last accumulate occurs in cycle 4+MUL_LATENCY.
- mul_en=0 outside ISSUE. mul_a and mul_b hold their last value when idle (don't-care to the multiplier).
- FIXUP (one cycle):
  - If neg, acc <= ~acc + 1.
  - resp_result <= (op=00) ? acc'[31:0] : acc'[63:32], where acc' is the post-fix-up value.
  - Go to RESP.
- RESP:
  - resp_valid=1; result held stable until resp_valid & resp_ready.
  - On handshake, go to IDLE with req_ready=1 the next cycle.
- Latency: accept at cycle 0 -> resp_valid first high at cycle 6+MUL_LATENCY (7 for default), assuming resp_ready is high.
- Back-pressure: resp_ready low holds RESP indefinitely; no new request is accepted.
- No overlap of requests: throughput is one op per 7+MUL_LATENCY cycles minimum.
- Handshake rules: req_valid is ignored outside IDLE. Request fields are sampled only on the accept edge; later changes have no effect.
- Simultaneous reset and handshake: reset wins.

Test Plan:
- MULXUU 0xFFFFFFFF x 0xFFFFFFFF -> resp_result 0xFFFFFFFE. Exactly 4 mul_en pulses; resp_valid at cycle 7 after accept.
- MUL 0x00010001 x 0x00010001 -> resp_result 0x00020001. Same op as MULXUU -> 0x00000001.
- MULXSS 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULXSS 0x80000000 x 0x80000000 -> 0x40000000. MULXSS 0xFFFFFFFE x 0x00000003 -> 0xFFFFFFFF.
- MULXSU 0xFFFFFFFF (-1) x 0xFFFFFFFF (unsigned) -> 0xFFFFFFFF. MULXSU 0x00000002 x 0x80000000 -> 0x00000001.
- resp_ready held low 10 cycles with req_valid high throughout:
  - result stays stable and req_ready stays 0;
  - second request is accepted the cycle after the response handshake.
- reset_n pulsed low during ISSUE pass 2 -> all outputs return to reset values next edge, no resp_valid. A following MULXUU 3x5 -> 0x00000000, with the MUL op giving 0x0000000F.
- Repeat the first and third scenarios with MUL_LATENCY=3 -> same results, resp_valid at cycle 9.
